// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// Per-instance widths are derived in the top module from its own parameters.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int NREQ_DEF  = 4;
  localparam int DW_DEF    = 8;
  localparam int BURST_DEF = 4;

  localparam int IDXW = $clog2(NREQ_DEF);
  localparam int CNTW = $clog2(BURST_DEF + 1);

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: the first requester at or after ptr, wrapping modulo NREQ.
// The wrap is explicit so that a non-power-of-2 NREQ never selects an out-of-range index.
module fifo_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  int j;

  // Scan from the farthest offset back to ptr, so the closest hit is written last and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter multiplexing NREQ producers onto the shared FIFO write port.
// Each grant tenure is limited to BURST words.
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | arbitration bubble: pick the next owner from ptr; no write happens
//   GRANT | owner writes while it requests and the FIFO is not full
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int BURST = BURST_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DW-1:0]        wdata,
  output logic [NREQ-1:0]           ack,
  input  logic                      fifo_full,
  output logic                      fifo_wrreq,
  output logic [DW-1:0]             fifo_wrdata,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(BURST + 1);

  arb_state_t        state, state_d;
  logic [IDX_W-1:0]  ptr, ptr_d;
  logic [IDX_W-1:0]  owner_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [IDX_W-1:0]  owner_nxt;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              wr;

  fifo_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_nxt = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      owner <= owner_d;
      cnt   <= cnt_d;
    end
  end

  // Outputs are gated with reset so nothing is written in the reset cycle itself.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    owner_d     = owner;
    cnt_d       = cnt;
    ack         = '0;
    wr          = 1'b0;
    fifo_wrdata = '0;
    busy        = (state == GRANT) && !reset;

    for (int i = 0; i < NREQ; i++) begin
      if (owner == IDX_W'(i)) fifo_wrdata = wdata[i*DW +: DW];
    end

    case (state)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        wr = req[owner] && !fifo_full && !reset;
        if (wr) begin
          ack[owner] = 1'b1;
          cnt_d      = cnt + CNT_W'(1);
          if (cnt == CNT_W'(BURST - 1)) begin
            state_d = IDLE;
            ptr_d   = owner_nxt;
          end
        end else if (!req[owner]) begin
          state_d = IDLE;
          ptr_d   = owner_nxt;
        end
      end
      default: state_d = IDLE;
    endcase

    fifo_wrreq = wr;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DW=8, BURST=4) with simple producer and depth-8 FIFO models.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        req = '0;
  logic [31:0]       wdata = '0;
  logic              fifo_full = 1'b0;
  logic [3:0]        ack;
  logic              fifo_wrreq;
  logic [7:0]        fifo_wrdata;
  logic [IDXW-1:0]   owner;
  logic              busy;

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata), .ack(ack),
    .fifo_full(fifo_full), .fifo_wrreq(fifo_wrreq), .fifo_wrdata(fifo_wrdata),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Producer model: en enables a requester, left counts remaining words (-1 = endless).
  logic [7:0]      data [4];
  int              left [4];
  logic [3:0]      en = '0;
  logic            rst_v = 1'b1;
  logic            full_v = 1'b0;
  logic [7:0]      fifo_q [$];
  int              tests = 0;
  int              fails = 0;

  logic [3:0]      o_ack;
  logic            o_wrreq;
  logic [7:0]      o_wrdata;
  logic [IDXW-1:0] o_owner;
  logic            o_busy;

  task automatic cycle();
    @(negedge clk);
    reset     = rst_v;
    fifo_full = full_v;
    for (int i = 0; i < 4; i++) begin
      req[i] = en[i] && (left[i] != 0);
      wdata[i*8 +: 8] = data[i];
    end
    #1;
    o_ack = ack; o_wrreq = fifo_wrreq; o_wrdata = fifo_wrdata; o_owner = owner; o_busy = busy;
    if (o_wrreq) begin
      tests++;
      if (fifo_q.size() >= 8) begin fails++; $display("FAIL fifo_overflow: size %0d, limit 8", fifo_q.size()); end
      else fifo_q.push_back(o_wrdata);
    end
    for (int i = 0; i < 4; i++) begin
      if (o_ack[i]) begin
        data[i] = data[i] + 8'd1;
        if (left[i] > 0) left[i] = left[i] - 1;
      end
    end
  endtask

  task automatic start_test();
    en = '0; full_v = 1'b0; rst_v = 1'b1;
    cycle();
    rst_v = 1'b0;
    fifo_q.delete();
    for (int i = 0; i < 4; i++) begin data[i] = '0; left[i] = -1; end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin data[i] = '0; left[i] = -1; end
    en = 4'b1111; rst_v = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      tests++; if (o_ack !== 4'b0000) begin fails++; $display("FAIL reset_ack: got %b expected 0000", o_ack); end
      tests++; if (o_wrreq !== 1'b0) begin fails++; $display("FAIL reset_wrreq: got %b expected 0", o_wrreq); end
      tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
      tests++; if (o_owner !== 2'd0) begin fails++; $display("FAIL reset_owner: got %0d expected 0", o_owner); end
    end
    rst_v = 1'b0;
    cycle();
    tests++; if (o_busy !== 1'b0 || o_wrreq !== 1'b0) begin fails++; $display("FAIL reset_bubble: busy %b wrreq %b expected 0 0", o_busy, o_wrreq); end
    cycle();
    tests++; if (o_busy !== 1'b1 || o_owner !== 2'd0) begin fails++; $display("FAIL reset_first_grant: busy %b owner %0d expected 1 0", o_busy, o_owner); end
    tests++; if (o_ack !== 4'b0001) begin fails++; $display("FAIL reset_first_ack: got %b expected 0001", o_ack); end
  endtask

  task automatic test_single_stream();
    logic       exp_wr [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] nxt = 8'h10;
    start_test();
    data[2] = 8'h10; en = 4'b0100;
    for (int t = 0; t < 7; t++) begin
      cycle();
      tests++; if (o_wrreq !== exp_wr[t]) begin fails++; $display("FAIL single_wrreq c%0d: got %b expected %b", t, o_wrreq, exp_wr[t]); end
      tests++; if (o_busy !== exp_wr[t]) begin fails++; $display("FAIL single_busy c%0d: got %b expected %b", t, o_busy, exp_wr[t]); end
      if (exp_wr[t]) begin
        tests++; if (o_wrdata !== nxt) begin fails++; $display("FAIL single_data c%0d: got %h expected %h", t, o_wrdata, nxt); end
        tests++; if (o_ack !== 4'b0100 || o_owner !== 2'd2) begin fails++; $display("FAIL single_owner c%0d: ack %b owner %0d expected 0100 2", t, o_ack, o_owner); end
        nxt = nxt + 8'd1;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] ev;
    start_test();
    for (int i = 0; i < 4; i++) data[i] = 8'(i * 16);
    en = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      cycle();
      tests++; if (o_busy !== 1'b0 || o_wrreq !== 1'b0) begin fails++; $display("FAIL rr_bubble t%0d: busy %b wrreq %b expected 0 0", t, o_busy, o_wrreq); end
      for (int k = 0; k < 4; k++) begin
        cycle();
        tests++; if (o_busy !== 1'b1 || o_wrreq !== 1'b1) begin fails++; $display("FAIL rr_beat t%0d k%0d: busy %b wrreq %b expected 1 1", t, k, o_busy, o_wrreq); end
        tests++; if (o_owner !== 2'(t % 4)) begin fails++; $display("FAIL rr_owner t%0d: got %0d expected %0d", t, o_owner, t % 4); end
      end
      tests++; if (fifo_q.size() != 4) begin fails++; $display("FAIL rr_count t%0d: got %0d expected 4", t, fifo_q.size()); end
      for (int k = 0; k < 4 && k < fifo_q.size(); k++) begin
        ev = 8'((t % 4) * 16 + (t / 4) * 4 + k);
        tests++; if (fifo_q[k] !== ev) begin fails++; $display("FAIL rr_fifo t%0d k%0d: got %h expected %h", t, k, fifo_q[k], ev); end
      end
      fifo_q.delete();
    end
  endtask

  task automatic test_full_stall();
    logic fullp [9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic exp_wr [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_bz [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    start_test();
    data[0] = 8'hA0; data[3] = 8'hD0; en = 4'b1001;
    for (int t = 0; t < 9; t++) begin
      full_v = fullp[t];
      cycle();
      tests++; if (o_wrreq !== exp_wr[t]) begin fails++; $display("FAIL full_wrreq c%0d: got %b expected %b", t, o_wrreq, exp_wr[t]); end
      tests++; if (o_busy !== exp_bz[t]) begin fails++; $display("FAIL full_busy c%0d: got %b expected %b", t, o_busy, exp_bz[t]); end
      if (fullp[t]) begin
        tests++; if (o_ack !== 4'b0000 || o_owner !== 2'd0) begin fails++; $display("FAIL full_stall c%0d: ack %b owner %0d expected 0000 0", t, o_ack, o_owner); end
      end
    end
    full_v = 1'b0;
    cycle();
    tests++; if (o_owner !== 2'd3 || o_wrdata !== 8'hD0) begin fails++; $display("FAIL full_next: owner %0d data %h expected 3 d0", o_owner, o_wrdata); end
    tests++; if (fifo_q.size() != 5) begin fails++; $display("FAIL full_count: got %0d expected 5", fifo_q.size()); end
    for (int k = 0; k < 4 && k < fifo_q.size(); k++) begin
      tests++; if (fifo_q[k] !== 8'(8'hA0 + k)) begin fails++; $display("FAIL full_fifo k%0d: got %h expected %h", k, fifo_q[k], 8'(8'hA0 + k)); end
    end
  endtask

  task automatic test_req_drop();
    start_test();
    data[0] = 8'h40; data[1] = 8'h50; data[3] = 8'h70;
    left[1] = 2; en = 4'b1010;
    cycle();
    tests++; if (o_wrreq !== 1'b0) begin fails++; $display("FAIL drop_bubble: got %b expected 0", o_wrreq); end
    cycle(); cycle();
    tests++; if (o_owner !== 2'd1 || o_wrreq !== 1'b1) begin fails++; $display("FAIL drop_owner1: owner %0d wrreq %b expected 1 1", o_owner, o_wrreq); end
    en[0] = 1'b1;
    cycle();
    tests++; if (o_busy !== 1'b1 || o_wrreq !== 1'b0 || o_ack !== 4'b0000) begin fails++; $display("FAIL drop_cycle: busy %b wrreq %b ack %b expected 1 0 0000", o_busy, o_wrreq, o_ack); end
    cycle();
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL drop_idle: busy %b expected 0", o_busy); end
    tests++; if (fifo_q.size() != 2) begin fails++; $display("FAIL drop_count: got %0d expected 2", fifo_q.size()); end
    else begin
      tests++; if (fifo_q[0] !== 8'h50 || fifo_q[1] !== 8'h51) begin fails++; $display("FAIL drop_fifo: got %h %h expected 50 51", fifo_q[0], fifo_q[1]); end
    end
    cycle();
    tests++; if (o_owner !== 2'd3 || o_wrdata !== 8'h70 || o_ack !== 4'b1000) begin fails++; $display("FAIL drop_next: owner %0d data %h ack %b expected 3 70 1000", o_owner, o_wrdata, o_ack); end
  endtask

  task automatic test_reset_mid_burst();
    start_test();
    data[0] = 8'h30; data[1] = 8'h90; data[2] = 8'hB0;
    left[1] = 1; en = 4'b0010;
    cycle(); cycle();
    en[2] = 1'b1;
    cycle(); cycle(); cycle();
    tests++; if (o_owner !== 2'd2 || o_wrdata !== 8'hB0 || o_wrreq !== 1'b1) begin fails++; $display("FAIL mid_beat1: owner %0d data %h wrreq %b expected 2 b0 1", o_owner, o_wrdata, o_wrreq); end
    rst_v = 1'b1; en[0] = 1'b1;
    cycle();
    tests++; if (o_wrreq !== 1'b0 || o_ack !== 4'b0000 || o_busy !== 1'b0) begin fails++; $display("FAIL mid_reset: wrreq %b ack %b busy %b expected 0 0000 0", o_wrreq, o_ack, o_busy); end
    rst_v = 1'b0;
    cycle();
    tests++; if (o_busy !== 1'b0 || o_wrreq !== 1'b0 || o_owner !== 2'd0) begin fails++; $display("FAIL mid_idle: busy %b wrreq %b owner %0d expected 0 0 0", o_busy, o_wrreq, o_owner); end
    tests++; if (fifo_q.size() != 2) begin fails++; $display("FAIL mid_count: got %0d expected 2", fifo_q.size()); end
    for (int k = 0; k < 5; k++) begin
      cycle();
      tests++; if (o_wrreq !== (k < 4)) begin fails++; $display("FAIL mid_restart_wr k%0d: got %b expected %b", k, o_wrreq, k < 4); end
      if (k < 4) begin
        tests++; if (o_owner !== 2'd0 || o_wrdata !== 8'(8'h30 + k)) begin fails++; $display("FAIL mid_restart k%0d: owner %0d data %h expected 0 %h", k, o_owner, o_wrdata, 8'(8'h30 + k)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_full_stall();
    test_req_drop();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
